// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, flush and valid-qualified RegWrite.
// Optional PIPE_STAGE_STATS_EN adds saturating stall_cnt/bubble_cnt outputs.
module pipe_stage_skid #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_DATA = 2,
   parameter int unsigned CTRL_W   = 1,
   parameter int unsigned REG_AW   = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_DATA*DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0]          in_ctrl,
   input  logic                       in_reg_write,
   input  logic [REG_AW-1:0]          in_rs1,
   input  logic [REG_AW-1:0]          in_rs2,
   input  logic [REG_AW-1:0]          in_rd,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_DATA*DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [REG_AW-1:0]          out_rs1,
   output logic [REG_AW-1:0]          out_rs2,
   output logic [REG_AW-1:0]          out_rd,
`ifdef PIPE_STAGE_STATS_EN
   output logic [31:0]                stall_cnt,
   output logic [31:0]                bubble_cnt,
`endif
   output logic                       out_reg_write
);

   localparam int unsigned PW = NUM_DATA * DATA_W + CTRL_W + 1 + 3 * REG_AW;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] FULL  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic          in_ready_q;
   logic [PW-1:0] main_q, skid_q, in_pay;
   logic          main_rw;
   logic          acc, rel;
   logic          load_in, load_skid, load_from_skid;

   assign in_pay = {in_data, in_ctrl, in_reg_write, in_rs1, in_rs2, in_rd};
   assign {out_data, out_ctrl, main_rw, out_rs1, out_rs2, out_rd} = main_q;

   assign in_ready      = in_ready_q;
   assign out_valid     = (state_q != EMPTY);
   assign out_reg_write = main_rw & out_valid;

   assign acc = in_valid & in_ready_q;
   assign rel = out_valid & out_ready;

   always_comb begin
      state_d        = state_q;
      load_in        = 1'b0;
      load_skid      = 1'b0;
      load_from_skid = 1'b0;
      case (state_q)
         EMPTY: begin
            if (acc) begin
               state_d = BUSY;
               load_in = 1'b1;
            end
         end
         BUSY: begin
            if (acc && rel) begin
               load_in = 1'b1;
            end else if (acc) begin
               state_d   = FULL;
               load_skid = 1'b1;
            end else if (rel) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (rel) begin
               state_d        = BUSY;
               load_from_skid = 1'b1;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush wins over everything; payload may stay stale since out_valid drops.
      if (flush) begin
         state_d        = EMPTY;
         load_in        = 1'b0;
         load_skid      = 1'b0;
         load_from_skid = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != FULL);
         if (load_in) begin
            main_q <= in_pay;
         end else if (load_from_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_pay;
         end
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   logic stall_inc, bubble_inc;

   assign stall_inc  = out_valid & ~out_ready;
   assign bubble_inc = ~out_valid | (flush & (out_valid | acc));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall_inc && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (bubble_inc && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random traffic against a queue model.
// Counter checks are compiled in when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_skid;

   typedef struct packed {
      logic [63:0] d;
      logic        c;
      logic        rw;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } beat_t;

   logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [63:0] in_data, out_data;
   logic        in_ctrl, out_ctrl, in_reg_write, out_reg_write;
   logic [4:0]  in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;
`ifdef PIPE_STAGE_STATS_EN
   logic [31:0] stall_cnt, bubble_cnt;
   int unsigned stall_m, bubble_m;
`endif

   int    checks = 0;
   int    errors = 0;
   beat_t q[$];
   beat_t cur;
   logic  rdy_m;

   pipe_stage_skid dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_ctrl      (in_ctrl),
      .in_reg_write (in_reg_write),
      .in_rs1       (in_rs1),
      .in_rs2       (in_rs2),
      .in_rd        (in_rd),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_ctrl     (out_ctrl),
      .out_rs1      (out_rs1),
      .out_rs2      (out_rs2),
      .out_rd       (out_rd),
`ifdef PIPE_STAGE_STATS_EN
      .stall_cnt    (stall_cnt),
      .bubble_cnt   (bubble_cnt),
`endif
      .out_reg_write(out_reg_write)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic beat_t rand_beat();
      beat_t b;
      b.d   = {$urandom, $urandom};
      b.c   = 1'($urandom);
      b.rw  = 1'($urandom);
      b.rs1 = 5'($urandom);
      b.rs2 = 5'($urandom);
      b.rd  = 5'($urandom);
      return b;
   endfunction

   task automatic drive(input logic iv, input logic fl, input logic ordy, input beat_t b);
      cur          = b;
      in_valid     = iv;
      flush        = fl;
      out_ready    = ordy;
      in_data      = b.d;
      in_ctrl      = b.c;
      in_reg_write = b.rw;
      in_rs1       = b.rs1;
      in_rs2       = b.rs2;
      in_rd        = b.rd;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".out_valid"}, out_valid, q.size() > 0);
      chk({tag, ".in_ready"}, in_ready, rdy_m);
      chk({tag, ".out_reg_write"}, out_reg_write, (q.size() > 0) ? q[0].rw : 1'b0);
      if (q.size() > 0) begin
         chk({tag, ".out_data"}, out_data, q[0].d);
         chk({tag, ".out_ctrl"}, out_ctrl, q[0].c);
         chk({tag, ".out_rs"}, {out_rs1, out_rs2, out_rd}, {q[0].rs1, q[0].rs2, q[0].rd});
      end
`ifdef PIPE_STAGE_STATS_EN
      chk({tag, ".stall_cnt"}, stall_cnt, stall_m);
      chk({tag, ".bubble_cnt"}, bubble_cnt, bubble_m);
`endif
   endtask

   // Model: the stage is a 2-deep FIFO whose ready flag reflects occupancy after the edge.
   task automatic step(input string tag);
      logic acc, rel;
      @(posedge clk);
      acc = in_valid && rdy_m;
      rel = (q.size() > 0) && out_ready;
`ifdef PIPE_STAGE_STATS_EN
      if ((q.size() > 0) && !out_ready) stall_m++;
      if ((q.size() == 0) || (flush && ((q.size() > 0) || acc))) bubble_m++;
`endif
      if (flush) begin
         q.delete();
      end else begin
         if (rel) void'(q.pop_front());
         if (acc) q.push_back(cur);
      end
      rdy_m = (q.size() < 2);
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic model_reset();
      q.delete();
      rdy_m = 1'b1;
`ifdef PIPE_STAGE_STATS_EN
      stall_m  = 0;
      bubble_m = 0;
`endif
   endtask

   initial begin
      beat_t a, b, z;
      z = '0;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b1, z);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_model("reset");
      chk("reset.out_data", out_data, 64'd0);
      chk("reset.out_rd", out_rd, 64'd0);

      // Back-to-back stream at full rate.
      for (int i = 0; i < 8; i++) begin
         a    = rand_beat();
         a.d  = 64'(i);
         a.rd = 5'(i);
         drive(1'b1, 1'b0, 1'b1, a);
         step("stream");
         chk("stream.order", out_data, 64'(i));
         chk("stream.in_ready", in_ready, 1'b1);
      end
      drive(1'b0, 1'b0, 1'b1, z);
      step("drain");

      // Fill skid while downstream stalls, then drain in order.
      a = rand_beat();
      b = rand_beat();
      drive(1'b1, 1'b0, 1'b0, a);
      step("fill_a");
      drive(1'b1, 1'b0, 1'b0, b);
      step("fill_b");
      chk("full.in_ready", in_ready, 1'b0);
      chk("full.hold_a", out_data, a.d);
      drive(1'b1, 1'b0, 1'b0, rand_beat());
      step("full_hold");
      chk("full.still_a", out_data, a.d);
      drive(1'b0, 1'b0, 1'b1, z);
      step("release_a");
      chk("release.b", out_data, b.d);
      step("release_b");

      // Flush while full and while a new beat is offered.
      drive(1'b1, 1'b0, 1'b0, rand_beat());
      step("f_fill_a");
      drive(1'b1, 1'b0, 1'b0, rand_beat());
      step("f_fill_b");
      drive(1'b1, 1'b1, 1'b0, rand_beat());
      step("flush");
      chk("flush.out_valid", out_valid, 1'b0);
      chk("flush.in_ready", in_ready, 1'b1);
      chk("flush.out_reg_write", out_reg_write, 1'b0);
      drive(1'b0, 1'b0, 1'b1, z);
      step("post_flush");

      // RegWrite qualified by valid.
      a    = rand_beat();
      a.rw = 1'b1;
      a.rd = 5'd5;
      drive(1'b1, 1'b0, 1'b1, a);
      step("rw_beat");
      chk("rw.asserted", out_reg_write, 1'b1);
      chk("rw.rd", out_rd, 64'd5);
      drive(1'b0, 1'b0, 1'b1, z);
      step("rw_idle");
      chk("rw.dropped", out_reg_write, 1'b0);

      // Asynchronous reset in the middle of a stall.
      a    = rand_beat();
      a.rw = 1'b1;
      drive(1'b1, 1'b0, 1'b0, a);
      step("pre_areset");
      drive(1'b0, 1'b0, 1'b0, z);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_model("areset");
      chk("areset.out_data", out_data, 64'd0);
      chk("areset.out_ids", {out_ctrl, out_rs1, out_rs2, out_rd}, 64'd0);
      @(negedge clk);
      reset = 1'b0;

`ifdef PIPE_STAGE_STATS_EN
      drive(1'b1, 1'b0, 1'b0, rand_beat());
      step("st_accept");
      drive(1'b0, 1'b0, 1'b0, z);
      repeat (3) step("st_stall");
      chk("stats.stall3", stall_cnt, 64'd3);
      drive(1'b1, 1'b1, 1'b0, rand_beat());
      step("st_flush");
      chk("stats.bubble_flush", bubble_cnt, 64'd2);
`endif

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom), ($urandom_range(15) == 0), 1'($urandom), rand_beat());
         step("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
